// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor controller.
package serial_sub_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: diff = a - b - borrow_in, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic diff,
    output logic borrow_out
);

    assign diff       = a ^ b ^ borrow_in;
    assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial unsigned subtractor: one bit per cycle through a single full
// subtractor, result and final borrow published on a one-cycle done pulse.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bor_q, bor_d;
    logic             bout_q, bout_d;

    logic cell_diff;
    logic cell_borrow;

    full_subtractor u_cell (
        .a          (a_sh_q[0]),
        .b          (b_sh_q[0]),
        .borrow_in  (bor_q),
        .diff       (cell_diff),
        .borrow_out (cell_borrow)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        bor_d   = bor_q;
        bout_d  = bout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    bor_d   = borrow_in;
                    res_d   = '0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                // Result fills from the MSB so bit 0 lands in place after WIDTH shifts.
                res_d  = {cell_diff, res_q[WIDTH-1:1]};
                bor_d  = cell_borrow;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    diff_d  = {cell_diff, res_q[WIDTH-1:1]};
                    bout_d  = cell_borrow;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            bor_q   <= 1'b0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            bor_q   <= bor_d;
            bout_q  <= bout_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = bout_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl at WIDTH=8; inputs driven #1 after
// the rising edge, outputs sampled on the falling edge.
module tb_serial_sub_ctrl;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         borrow_in;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;

    int checks   = 0;
    int failures = 0;
    exp_t sbq[$];
    logic [W-1:0] last_diff = '0;
    logic         last_bo   = 1'b0;

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] t;
        t = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
        model.d  = t[W-1:0];
        model.bo = t[W];
    endfunction

    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'h00; borrow_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || borrow_out !== 1'b0) begin
                failures++;
                $display("FAIL reset: busy=%b done=%b diff=%h bo=%b, want 0 0 00 0", busy, done, diff, borrow_out);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0; start = 1'b0;
    endtask

    task automatic test_vectors();
        logic [W-1:0] va [8];
        logic [W-1:0] vb [8];
        logic         vc [8];
        va = '{8'h5A, 8'h00, 8'h80, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        vb = '{8'h3C, 8'h01, 8'h7F, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        vc = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 4; i < 8; i++) begin
            va[i] = W'($urandom_range(0, 255));
            vb[i] = W'($urandom_range(0, 255));
            vc[i] = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            int   k;
            bit   got;
            @(posedge clk); #1;
            a = va[i]; b = vb[i]; borrow_in = vc[i]; start = 1'b1;
            sbq.push_back(model(va[i], vb[i], vc[i]));
            got = 0;
            k = 0;
            while (!got && k <= W + 4) begin
                @(negedge clk);
                if (k == 0) begin
                    checks++;
                    if (busy !== 1'b0) begin
                        failures++;
                        $display("FAIL vec%0d_idle_busy: busy=%b want 0", i, busy);
                    end
                end else if (done === 1'b1) begin
                    got = 1;
                    checks++;
                    if (sbq.size() == 0) begin
                        failures++;
                        $display("FAIL vec%0d_unexpected_done: queue empty", i);
                    end else begin
                        e = sbq.pop_front();
                        if (diff !== e.d || borrow_out !== e.bo) begin
                            failures++;
                            $display("FAIL vec%0d_result: diff=%h bo=%b, want diff=%h bo=%b", i, diff, borrow_out, e.d, e.bo);
                        end
                        last_diff = e.d;
                        last_bo   = e.bo;
                    end
                    checks++;
                    if (k != W + 1) begin
                        failures++;
                        $display("FAIL vec%0d_latency: done at cycle %0d, want %0d", i, k, W + 1);
                    end
                end else begin
                    checks++;
                    if (busy !== 1'b1 || diff !== last_diff || borrow_out !== last_bo) begin
                        failures++;
                        $display("FAIL vec%0d_hold c%0d: busy=%b diff=%h bo=%b, want 1 %h %b", i, k, busy, diff, borrow_out, last_diff, last_bo);
                    end
                end
                @(posedge clk); #1;
                // Operands scrambled after acceptance must not reach the result.
                start = 1'b0;
                a = W'($urandom); b = W'($urandom); borrow_in = 1'($urandom);
                k++;
            end
            if (!got) begin
                checks++; failures++;
                $display("FAIL vec%0d_timeout: no done within %0d cycles, want done at %0d", i, W + 5, W + 1);
                void'(sbq.pop_front());
            end
        end
    endtask

    task automatic test_ignore_start();
        exp_t e;
        @(posedge clk); #1;
        a = 8'h10; b = 8'h01; borrow_in = 1'b0; start = 1'b1;
        sbq.push_back(model(8'h10, 8'h01, 1'b0));
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            checks++;
            if (done !== (k == W + 1)) begin
                failures++;
                $display("FAIL ignore_done c%0d: done=%b want %b", k, done, (k == W + 1));
            end
            if (k == W + 1 && done === 1'b1) begin
                checks++;
                e = sbq.pop_front();
                if (diff !== e.d || borrow_out !== e.bo || diff !== 8'h0F) begin
                    failures++;
                    $display("FAIL ignore_result: diff=%h bo=%b, want diff=%h bo=%b", diff, borrow_out, e.d, e.bo);
                end
                last_diff = e.d;
                last_bo   = e.bo;
            end
            @(posedge clk); #1;
            start = (k + 1 == 3);
            if (k + 1 == 3) begin
                a = 8'hFF; b = 8'h00;
            end
        end
        if (sbq.size() != 0) begin
            checks++; failures++;
            $display("FAIL ignore_missing_done: %0d pending, want 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        a = 8'h33; b = 8'h11; borrow_in = 1'b0; start = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_done c%0d: done=%b want 0", k, done);
            end
            if (k == 5) begin
                checks++;
                if (busy !== 1'b0 || diff !== 8'h00 || borrow_out !== 1'b0) begin
                    failures++;
                    $display("FAIL rstmid_state: busy=%b diff=%h bo=%b, want 0 00 0", busy, diff, borrow_out);
                end
            end
            if (k == 3) begin
                checks++;
                if (busy !== 1'b1 || diff !== last_diff) begin
                    failures++;
                    $display("FAIL rstmid_pre: busy=%b diff=%h, want 1 %h", busy, diff, last_diff);
                end
            end
            @(posedge clk); #1;
            start = 1'b0;
            rst = (k + 1 == 4);
        end
        last_diff = '0;
        last_bo   = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bit   exp_busy;
        bit   exp_done;
        @(posedge clk); #1;
        start = 1'b1; a = 8'hC3; b = 8'h5D; borrow_in = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (k == 0 || k == 10 || k == 20) sbq.push_back(model(a, b, borrow_in));
            exp_busy = !(k == 0 || k == 10 || k == 20);
            exp_done = (k == 9 || k == 19 || k == 29);
            @(negedge clk);
            checks++;
            if (busy !== exp_busy || done !== exp_done) begin
                failures++;
                $display("FAIL b2b c%0d: busy=%b done=%b, want busy=%b done=%b", k, busy, done, exp_busy, exp_done);
            end
            if (done === 1'b1 && sbq.size() > 0) begin
                e = sbq.pop_front();
                checks++;
                if (diff !== e.d || borrow_out !== e.bo) begin
                    failures++;
                    $display("FAIL b2b_result c%0d: diff=%h bo=%b, want diff=%h bo=%b", k, diff, borrow_out, e.d, e.bo);
                end
            end
            @(posedge clk); #1;
            a = W'($urandom); b = W'($urandom); borrow_in = 1'($urandom);
        end
        start = 1'b0;
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL b2b_pending: %0d results never produced, want 0", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
        test_reset();
        test_vectors();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_sub_ctrl.md
SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; WIDTH SHALL be >= 2.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  request a subtraction; sampled only in IDLE.
REQ-006 a  input  WIDTH  minuend, unsigned; captured on accepted start.
REQ-007 b  input  WIDTH  subtrahend, unsigned; captured on accepted start.
REQ-008 borrow_in  input  1  initial borrow; captured on accepted start.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 done  output  1  one-cycle pulse when the result is valid.
REQ-011 diff  output  WIDTH  registered result of a - b - borrow_in mod 2^WIDTH.
REQ-012 borrow_out  output  1  registered final borrow; 1 iff a < b + borrow_in (unsigned).

Function
REQ-013 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-014 IDLE -> SHIFT when start=1; this is cycle 0. a, b and borrow_in are latched into internal shift and borrow registers, and the bit counter is cleared.
REQ-015 IDLE with start=0 SHALL remain in IDLE.
REQ-016 In SHIFT, each cycle SHALL feed the operand LSBs and the borrow register to one full-subtractor cell.
- Shift the operands right by 1.
- Shift the cell's diff bit into the internal result MSB.
- Load the cell's borrow into the borrow register.
- Increment the counter.
REQ-017 SHIFT cycles 1..WIDTH SHALL process bit 0..WIDTH-1; SHIFT -> DONE after the cycle in which the counter equals WIDTH-1.
REQ-018 On entry to DONE (cycle WIDTH+1), diff and borrow_out SHALL load the internal result and final borrow, and done SHALL be 1 for exactly that cycle.
REQ-019 DONE -> IDLE unconditionally; total latency from accepted start to done is WIDTH+1 cycles.
REQ-020 diff and borrow_out SHALL hold the previous result throughout SHIFT and IDLE, changing only on DONE entry.
REQ-021 start in SHIFT or DONE SHALL be ignored (no queuing); operand changes after acceptance SHALL NOT affect the result.
REQ-022 With start held high continuously, a new operation SHALL be accepted every WIDTH+2 cycles.
REQ-023 The counter width SHALL be $clog2(WIDTH) bits and SHALL never exceed WIDTH-1.

Reset
REQ-024 rst=1 at a clock edge SHALL force:
- state IDLE; busy=0, done=0;
- diff=0, borrow_out=0;
- counter, shift registers and borrow register cleared.
REQ-025 Reset SHALL dominate start in the same cycle.
REQ-026 Reset mid-operation SHALL abort the operation with no done pulse.

Structure
REQ-027 Package serial_sub_pkg SHALL hold the state enum type and the default WIDTH constant.
REQ-028 The single-bit cell SHALL be one instance of the team's existing full_subtractor module (ports a, b, borrow_in, diff, borrow_out); no other sub-module.

Verification (WIDTH=8)
REQ-029 a=8'h5A, b=8'h3C, borrow_in=0, start pulse -> done at cycle 9, diff=8'h1E, borrow_out=0.
REQ-030 a=8'h00, b=8'h01, borrow_in=0 -> diff=8'hFF, borrow_out=1.
REQ-031 a=8'h80, b=8'h7F, borrow_in=1 -> diff=8'h00, borrow_out=0.
REQ-032 Start with a=8'h10, b=8'h01; at cycle 3 start=1 with a=8'hFF, b=8'h00 -> the single done gives diff=8'h0F; no second done until a new start in IDLE.
REQ-033 rst=1 at cycle 4 of an operation -> next cycle busy=0, done never pulses, diff=8'h00, borrow_out=0.
REQ-034 start held high for 30 cycles -> done pulses at cycles 9, 19, 29; busy low exactly at cycles 10, 20.
